selectable_output_xfade: RTL and testbench

- Parametrised N:1 registered output multiplexer for signed DAC/monitor channels.
- When the channel select changes, the output crossfades linearly from the old channel to the new one over 2^RAMP_LOG2 clock cycles, so the analog output never sees a step.
- Sits between the servo/filter cores and the DAC output drivers.
- Replaces the fixed 3-input, immediate-switch selectors.

---
 rtl/selout_pkg.sv | 19 +
 rtl/selout_interp.sv | 34 +++
 rtl/selectable_output_xfade.sv | 126 ++++++++++++
 tb/tb_selectable_output_xfade.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/selout_pkg.sv
// Shared types and defaults for the crossfading output selector.
// Crossfade is built only when SELOUT_XFADE_EN is defined.
package selout_pkg;

  typedef enum logic {
    IDLE,
    FADE
  } state_t;

  localparam int N_CH_DEF      = 8;
  localparam int W_DEF         = 16;
  localparam int SEL_W_DEF     = 6;
  localparam int RAMP_LOG2_DEF = 8;

  function automatic int prod_w(input int w, input int r);
    return w + r + 2;
  endfunction

endpackage

// File: rtl/selout_interp.sv
// Linear interpolator: y = a + ((b - a) * cnt) >>> RAMP_LOG2.
// Pure combinational; cnt < 2^RAMP_LOG2 keeps y between a and b.
module selout_interp
  import selout_pkg::*;
#(
  parameter int W         = W_DEF,
  parameter int RAMP_LOG2 = RAMP_LOG2_DEF
) (
  input  logic signed [W-1:0]         a,
  input  logic signed [W-1:0]         b,
  input  logic        [RAMP_LOG2-1:0] cnt,
  output logic signed [W-1:0]         y
);

  localparam int PW = prod_w(W, RAMP_LOG2);

  logic signed [W:0]    diff;
  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] sum;

  always_comb begin
    diff = {b[W-1], b} - {a[W-1], a};
    prod = PW'(diff) * $signed(PW'(cnt));
    sum  = PW'(a) + (prod >>> RAMP_LOG2);
    y    = sum[W-1:0];
  end

  // Convex combination: upper bits must be a pure sign extension.
  always_comb begin
    a_fits: assert ((&sum[PW-1:W-1]) || !(|sum[PW-1:W-1]))
      else $error("selout_interp: result exceeds W bits");
  end

endmodule

// File: rtl/selectable_output_xfade.sv
// N:1 registered output selector for signed DAC channels.
// With SELOUT_XFADE_EN defined, select changes crossfade linearly.
module selectable_output_xfade
  import selout_pkg::*;
#(
  parameter int N_CH      = N_CH_DEF,
  parameter int W         = W_DEF,
  parameter int SEL_W     = SEL_W_DEF,
  parameter int RAMP_LOG2 = RAMP_LOG2_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [SEL_W-1:0]      sel,
  input  logic [N_CH*W-1:0]     in_bus,
  output logic signed [W-1:0]   out,
  output logic [SEL_W-1:0]      sel_cur,
  output logic                  busy,
  output logic                  sel_err
);

  localparam logic [SEL_W:0] NCH = (SEL_W+1)'(N_CH);

  logic               valid;
  logic signed [W-1:0] cur_s;

  assign valid = ({1'b0, sel} < NCH);
  assign cur_s = in_bus[int'(sel_cur)*W +: W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sel_err <= 1'b0;
    else        sel_err <= !valid;
  end

`ifdef SELOUT_XFADE_EN

  state_t               state, state_n;
  logic [SEL_W-1:0]     nxt, nxt_n;
  logic [SEL_W-1:0]     sel_cur_n;
  logic [RAMP_LOG2-1:0] cnt, cnt_n;
  logic                 busy_n;
  logic signed [W-1:0]  out_n;
  logic signed [W-1:0]  nxt_s;
  logic signed [W-1:0]  fade_y;

  assign nxt_s = in_bus[int'(nxt)*W +: W];

  selout_interp #(
    .W        (W),
    .RAMP_LOG2(RAMP_LOG2)
  ) u_interp (
    .a  (cur_s),
    .b  (nxt_s),
    .cnt(cnt),
    .y  (fade_y)
  );

  always_comb begin
    state_n   = state;
    nxt_n     = nxt;
    cnt_n     = cnt;
    sel_cur_n = sel_cur;
    busy_n    = busy;
    out_n     = cur_s;
    unique case (state)
      IDLE: begin
        if (valid && sel != sel_cur) begin
          nxt_n   = sel;
          cnt_n   = '0;
          busy_n  = 1'b1;
          state_n = FADE;
        end
      end
      FADE: begin
        out_n = fade_y;
        cnt_n = cnt + 1'b1;
        if (cnt == '1) begin
          sel_cur_n = nxt;
          busy_n    = 1'b0;
          state_n   = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      nxt     <= '0;
      cnt     <= '0;
      sel_cur <= '0;
      busy    <= 1'b0;
      out     <= '0;
    end else begin
      state   <= state_n;
      nxt     <= nxt_n;
      cnt     <= cnt_n;
      sel_cur <= sel_cur_n;
      busy    <= busy_n;
      out     <= out_n;
    end
  end

`else

  logic signed [W-1:0] req_s;

  assign req_s = in_bus[int'(sel)*W +: W];
  assign busy  = 1'b0;

  // Out-of-range select holds both the output and the channel index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_cur <= '0;
      out     <= '0;
    end else if (valid) begin
      sel_cur <= sel;
      out     <= req_s;
    end
  end

  logic unused_cur;
  assign unused_cur = ^cur_s;

`endif

endmodule

// File: tb/tb_selectable_output_xfade.sv
// Scoreboard bench for selectable_output_xfade (RAMP_LOG2=2)
// and an exhaustive check of selout_interp at W=4.
module tb_selectable_output_xfade;

  localparam int N_CH  = 8;
  localparam int W     = 16;
  localparam int SEL_W = 6;
  localparam int RL    = 2;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [SEL_W-1:0]    sel;
  logic [N_CH*W-1:0]   in_bus;
  logic signed [W-1:0] out;
  logic [SEL_W-1:0]    sel_cur;
  logic                busy;
  logic                sel_err;

  logic signed [3:0] ia, ib, iy;
  logic [1:0]        icnt;

  typedef struct packed {
    logic signed [15:0] o;
    logic [5:0]         sc;
    logic               b;
    logic               e;
  } obs_t;

  obs_t              sb[$];
  logic signed [3:0] iq[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  selectable_output_xfade #(
    .N_CH(N_CH), .W(W), .SEL_W(SEL_W), .RAMP_LOG2(RL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sel(sel), .in_bus(in_bus),
    .out(out), .sel_cur(sel_cur), .busy(busy), .sel_err(sel_err)
  );

  selout_interp #(.W(4), .RAMP_LOG2(2)) u_ip (
    .a(ia), .b(ib), .cnt(icnt), .y(iy)
  );

  function automatic obs_t mk(int o, int sc, bit b, bit e);
    obs_t r;
    r.o  = 16'(o);
    r.sc = 6'(sc);
    r.b  = b;
    r.e  = e;
    return r;
  endfunction

  task automatic set_in(input int k, input int v);
    in_bus[k*W +: W] = W'(v);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    obs_t got, exp;
    rst_n  = 1'b0;
    sel    = '0;
    in_bus = '0;
    set_in(0, 1000);
    #12;
    got = {out, sel_cur, busy, sel_err};
    exp = mk(0, 0, 0, 0);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL reset_hold: got %p want %p", got, exp);
    end
    @(negedge clk);
    rst_n = 1'b1;
    sb.push_back(mk(1000, 0, 0, 0));
    @(posedge clk);
    #1;
    exp = sb.pop_front();
    got = {out, sel_cur, busy, sel_err};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL reset_release: got %p want %p", got, exp);
    end
  endtask

`ifdef SELOUT_XFADE_EN
  task automatic test_fade_ramp();
    obs_t got, exp;
    int   i;
    set_in(0, 0);
    set_in(3, 400);
    wait_cyc(1);
    sel = 6'd3;
    sb.push_back(mk(0,   0, 1, 0));
    sb.push_back(mk(0,   0, 1, 0));
    sb.push_back(mk(100, 0, 1, 0));
    sb.push_back(mk(200, 0, 1, 0));
    sb.push_back(mk(300, 3, 0, 0));
    sb.push_back(mk(400, 3, 0, 0));
    i = 0;
    while (sb.size() > 0) begin
      @(posedge clk);
      #1;
      exp = sb.pop_front();
      got = {out, sel_cur, busy, sel_err};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL fade_ramp[%0d]: got %p want %p", i, got, exp);
      end
      i++;
    end
  endtask

  task automatic test_negative_span();
    obs_t got, exp;
    int   i;
    set_in(1, -32768);
    set_in(2, 32767);
    sel = 6'd1;
    wait_cyc(7);
    sel = 6'd2;
    sb.push_back(mk(-32768, 1, 1, 0));
    sb.push_back(mk(-32768, 1, 1, 0));
    sb.push_back(mk(-16385, 1, 1, 0));
    sb.push_back(mk(-1,     1, 1, 0));
    sb.push_back(mk(16383,  2, 0, 0));
    sb.push_back(mk(32767,  2, 0, 0));
    i = 0;
    while (sb.size() > 0) begin
      @(posedge clk);
      #1;
      exp = sb.pop_front();
      got = {out, sel_cur, busy, sel_err};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL neg_span[%0d]: got %p want %p", i, got, exp);
      end
      i++;
    end
  endtask

  task automatic test_mid_fade_sel();
    obs_t got, exp;
    int   i;
    set_in(0, 0);
    set_in(3, 400);
    set_in(5, 800);
    sel = 6'd0;
    wait_cyc(7);
    sel = 6'd3;
    sb.push_back(mk(0,   0, 1, 0));
    sb.push_back(mk(0,   0, 1, 0));
    sb.push_back(mk(100, 0, 1, 0));
    sb.push_back(mk(200, 0, 1, 0));
    sb.push_back(mk(300, 3, 0, 0));
    sb.push_back(mk(400, 3, 1, 0));
    sb.push_back(mk(400, 3, 1, 0));
    sb.push_back(mk(500, 3, 1, 0));
    sb.push_back(mk(600, 3, 1, 0));
    sb.push_back(mk(700, 5, 0, 0));
    sb.push_back(mk(800, 5, 0, 0));
    i = 0;
    while (sb.size() > 0) begin
      @(posedge clk);
      #1;
      exp = sb.pop_front();
      got = {out, sel_cur, busy, sel_err};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL mid_fade[%0d]: got %p want %p", i, got, exp);
      end
      if (i == 1) sel = 6'd5;
      i++;
    end
  endtask
`else
  task automatic test_immediate();
    obs_t got, exp;
    set_in(0, 1000);
    set_in(3, -500);
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: begin
          sel = 6'd3;
          sb.push_back(mk(-500, 3, 0, 0));
        end
        1: begin
          sel = 6'd9;
          set_in(3, 7);
          sb.push_back(mk(-500, 3, 0, 1));
        end
        default: begin
          sel = 6'd0;
          sb.push_back(mk(1000, 0, 0, 0));
        end
      endcase
      @(posedge clk);
      #1;
      exp = sb.pop_front();
      got = {out, sel_cur, busy, sel_err};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL immediate[%0d]: got %p want %p", i, got, exp);
      end
    end
  endtask
`endif

  task automatic test_out_of_range();
    obs_t got, exp;
    int   i;
    set_in(2, 1234);
    sel = 6'd2;
    wait_cyc(7);
    sel = 6'd9;
    sb.push_back(mk(1234, 2, 0, 1));
    sb.push_back(mk(1234, 2, 0, 1));
    sb.push_back(mk(1234, 2, 0, 0));
    i = 0;
    while (sb.size() > 0) begin
      @(posedge clk);
      #1;
      exp = sb.pop_front();
      got = {out, sel_cur, busy, sel_err};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL out_of_range[%0d]: got %p want %p", i, got, exp);
      end
      if (i == 1) sel = 6'd2;
      i++;
    end
  endtask

  task automatic test_reset_async();
    obs_t got, exp;
    set_in(0, 555);
    sel = 6'd0;
    wait_cyc(2);
    #2;
    rst_n = 1'b0;
    #1;
    got = {out, sel_cur, busy, sel_err};
    exp = mk(0, 0, 0, 0);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL reset_async: got %p want %p", got, exp);
    end
    @(negedge clk);
    rst_n = 1'b1;
    sb.push_back(mk(555, 0, 0, 0));
    sb.push_back(mk(555, 0, 0, 0));
    while (sb.size() > 0) begin
      @(posedge clk);
      #1;
      exp = sb.pop_front();
      got = {out, sel_cur, busy, sel_err};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL reset_no_resume: got %p want %p", got, exp);
      end
    end
  endtask

  task automatic test_interp();
    logic signed [3:0] exp;
    for (int a = -8; a < 8; a++) begin
      for (int b = -8; b < 8; b++) begin
        for (int c = 0; c < 4; c++) begin
          ia   = 4'(a);
          ib   = 4'(b);
          icnt = 2'(c);
          iq.push_back(4'(a + (((b - a) * c) >>> 2)));
          #1;
          exp = iq.pop_front();
          checks++;
          if (iy !== exp) begin
            errors++;
            $display("FAIL interp a=%0d b=%0d cnt=%0d: got %0d want %0d",
                     a, b, c, iy, exp);
          end
        end
      end
    end
  endtask

  initial begin
    ia   = '0;
    ib   = '0;
    icnt = '0;
    test_reset();
`ifdef SELOUT_XFADE_EN
    test_fade_ramp();
    test_negative_span();
    test_mid_fade_sel();
`else
    test_immediate();
`endif
    test_out_of_range();
    test_reset_async();
    test_interp();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
